// File: rtl/commit_trace_monitor_pkg.sv
// Shared definitions for the commit trace monitor: defaults, monitor states and
// the trace record layout stored in the FIFO.
package commit_trace_monitor_pkg;

   localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] DEF_HALT_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      MON_RUN   = 2'd0,
      MON_DRAIN = 2'd1,
      MON_DONE  = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic        mispred;
      logic [31:0] pc;
      logic [31:0] instr;
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/commit_trace_monitor_if.sv
// Retire stream plus trace read port between the CPU/reader side (master)
// and the monitor (slave).
interface commit_trace_monitor_if;
   logic        commit;
   logic [31:0] commit_pc;
   logic [31:0] commit_pre_pc;
   logic [31:0] commit_pred_pc;
   logic [31:0] instr;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic        rd_mispred;

   modport master (
      output commit, commit_pc, commit_pre_pc, commit_pred_pc, instr, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_mispred
   );

   modport slave (
      input  commit, commit_pc, commit_pre_pc, commit_pred_pc, instr, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_mispred
   );
endinterface

// File: rtl/commit_trace_monitor_trace_fifo.sv
// Synchronous trace FIFO with wrap-bit pointers; the head is read straight from
// the storage registers so it holds steady until popped.
module trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4,
   parameter int unsigned W     = 65
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   logic [W-1:0]   mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[PTR_W-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end
endmodule

// File: rtl/commit_trace_monitor.sv
// Retire-stream monitor: PC continuity checker, saturating counters, trace
// buffering and the halt sequencing FSM.
//
//   state     | meaning
//   MON_RUN   | commits counted, checked and pushed into the trace FIFO
//   MON_DRAIN | halt seen; commits counted and checked but dropped; waiting for empty FIFO
//   MON_DONE  | trace complete; commits ignored until reset
module commit_trace_monitor
   import commit_trace_monitor_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PTR_W      = 4,
   parameter int unsigned CNT_W      = 32,
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] HALT_INSTR = DEF_HALT_INSTR
) (
   input  logic                 clk,
   input  logic                 rst,
   commit_trace_monitor_if.slave bus,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [CNT_W-1:0]     mispred_cnt,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 pc_err,
   output logic [31:0]          err_pc,
   output logic                 done
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mon_state_e  state;
   mon_state_e  state_nxt;
   logic [31:0] exp_pc;
   logic        sample;
   logic        is_halt;
   logic        mispred;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        drop;
   logic        fifo_full;
   logic        fifo_empty;
   trace_rec_t  rec_in;
   trace_rec_t  rec_head;

   always_comb begin
      sample         = bus.commit && (state != MON_DONE);
      is_halt        = (bus.instr == HALT_INSTR);
      mispred        = (bus.commit_pre_pc != bus.commit_pred_pc);
      push_req       = sample && (state == MON_RUN);
      push           = push_req && !fifo_full;
      drop           = (push_req && fifo_full) || (sample && (state == MON_DRAIN));
      pop            = !fifo_empty && bus.rd_ready;
      rec_in         = '0;
      rec_in.mispred = mispred;
      rec_in.pc      = bus.commit_pc;
      rec_in.instr   = bus.instr;
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     (REC_W)
   ) u_trace_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (rec_in),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (rec_head)
   );

   assign bus.rd_valid   = !fifo_empty;
   assign bus.rd_pc      = rec_head.pc;
   assign bus.rd_instr   = rec_head.instr;
   assign bus.rd_mispred = rec_head.mispred;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MON_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MON_RUN:   if (sample && is_halt) state_nxt = MON_DRAIN;
         MON_DRAIN: if (fifo_empty)        state_nxt = MON_DONE;
         MON_DONE:  state_nxt = MON_DONE;
         default:   state_nxt = MON_RUN;
      endcase
   end

   assign done = (state == MON_DONE);

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt  <= '0;
         mispred_cnt <= '0;
         drop_cnt    <= '0;
         exp_pc      <= RESET_PC;
         pc_err      <= 1'b0;
         err_pc      <= '0;
      end else begin
         if (sample && (retire_cnt != CNT_MAX)) begin
            retire_cnt <= retire_cnt + CNT_ONE;
         end
         if (sample && mispred && (mispred_cnt != CNT_MAX)) begin
            mispred_cnt <= mispred_cnt + CNT_ONE;
         end
         if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
         end
         if (sample) begin
            exp_pc <= bus.commit_pre_pc;
         end
         if (sample && !pc_err && (bus.commit_pc != exp_pc)) begin
            pc_err <= 1'b1;
            err_pc <= bus.commit_pc;
         end
      end
   end
endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor: a queue-based model checked every
// cycle, plus literal expectations per scenario.
module tb_commit_trace_monitor;
   import commit_trace_monitor_pkg::*;

   localparam int          DEPTH = 16;
   localparam logic [31:0] RPC   = 32'h8000_0000;
   localparam logic [31:0] HALT  = 32'h0010_0073;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   commit_trace_monitor_if bus ();
   logic [31:0] retire_cnt, mispred_cnt, drop_cnt, err_pc;
   logic        pc_err, done;

   commit_trace_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .retire_cnt  (retire_cnt),
      .mispred_cnt (mispred_cnt),
      .drop_cnt    (drop_cnt),
      .pc_err      (pc_err),
      .err_pc      (err_pc),
      .done        (done)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: trace queue, counters, halt/done flags.
   bit          m_on = 0;
   logic [31:0] m_ret, m_mis, m_drop, m_exp, m_errpc;
   bit          m_err, m_halted, m_done;
   trace_rec_t  mq[$];
   trace_rec_t  got[$];

   function automatic logic [31:0] sat(logic [31:0] v);
      return (v == 32'hffff_ffff) ? v : v + 32'd1;
   endfunction

   task automatic model_step();
      int         occ;
      bit         do_pop;
      bit         halted_before;
      trace_rec_t r;
      if (rst) begin
         m_on = 1; m_ret = 0; m_mis = 0; m_drop = 0; m_exp = RPC; m_errpc = 0;
         m_err = 0; m_halted = 0; m_done = 0;
         mq.delete();
      end else if (m_on) begin
         occ           = mq.size();
         do_pop        = (occ > 0) && bus.rd_ready;
         halted_before = m_halted;
         if (bus.commit && !m_done) begin
            m_ret = sat(m_ret);
            if (bus.commit_pre_pc != bus.commit_pred_pc) m_mis = sat(m_mis);
            if (!m_err && bus.commit_pc != m_exp) begin
               m_err   = 1;
               m_errpc = bus.commit_pc;
            end
            m_exp = bus.commit_pre_pc;
            if (m_halted || occ == DEPTH) begin
               m_drop = sat(m_drop);
            end else begin
               r.mispred = (bus.commit_pre_pc != bus.commit_pred_pc);
               r.pc      = bus.commit_pc;
               r.instr   = bus.instr;
               mq.push_back(r);
            end
            if (!m_halted && bus.instr == HALT) m_halted = 1;
         end
         if (do_pop) void'(mq.pop_front());
         if (halted_before && !m_done && occ == 0) m_done = 1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      trace_rec_t r;
      @(negedge clk);
      if (m_on) begin
         check("rd_valid", bus.rd_valid, mq.size() > 0);
         if (mq.size() > 0) begin
            check("rd_pc", bus.rd_pc, mq[0].pc);
            check("rd_instr", bus.rd_instr, mq[0].instr);
            check("rd_mispred", bus.rd_mispred, mq[0].mispred);
         end
         check("retire_cnt", retire_cnt, m_ret);
         check("mispred_cnt", mispred_cnt, m_mis);
         check("drop_cnt", drop_cnt, m_drop);
         check("pc_err", pc_err, m_err);
         check("err_pc", err_pc, m_errpc);
         check("done", done, m_done);
         if (bus.rd_valid && bus.rd_ready) begin
            r.mispred = bus.rd_mispred;
            r.pc      = bus.rd_pc;
            r.instr   = bus.rd_instr;
            got.push_back(r);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      got.delete();
   endtask

   task automatic do_commit(logic [31:0] pc, logic [31:0] pre, logic [31:0] pred, logic [31:0] ins);
      bus.commit         = 1'b1;
      bus.commit_pc      = pc;
      bus.commit_pre_pc  = pre;
      bus.commit_pred_pc = pred;
      bus.instr          = ins;
      step();
      bus.commit = 1'b0;
   endtask

   task automatic seq(logic [31:0] pc);
      do_commit(pc, pc + 32'd4, pc + 32'd4, NOP);
   endtask

   initial begin
      int empty_cyc;
      int done_cyc;
      bus.commit = 0; bus.commit_pc = 0; bus.commit_pre_pc = 0;
      bus.commit_pred_pc = 0; bus.instr = 0; bus.rd_ready = 0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("reset rd_valid", bus.rd_valid, 0);
      check("reset retire_cnt", retire_cnt, 0);
      check("reset pc_err", pc_err, 0);
      check("reset err_pc", err_pc, 0);
      check("reset done", done, 0);

      // Sequential stream
      bus.rd_ready = 1;
      for (int i = 0; i < 5; i++) seq(RPC + 32'(4 * i));
      step(); step(); step();
      check("seq retire_cnt", retire_cnt, 5);
      check("seq mispred_cnt", mispred_cnt, 0);
      check("seq pc_err", pc_err, 0);
      check("seq record count", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         check("seq record pc", got[i].pc, RPC + 32'(4 * i));
         check("seq record mispred", got[i].mispred, 0);
      end

      // Mispredict
      do_reset();
      do_commit(32'h8000_0000, 32'h8000_0100, 32'h8000_0004, NOP);
      seq(32'h8000_0100);
      step(); step();
      check("mis mispred_cnt", mispred_cnt, 1);
      check("mis pc_err", pc_err, 0);
      check("mis record count", got.size(), 2);
      if (got.size() == 2) begin
         check("mis first rd_mispred", got[0].mispred, 1);
         check("mis second rd_mispred", got[1].mispred, 0);
         check("mis second pc", got[1].pc, 32'h8000_0100);
      end

      // Continuity break, err_pc sticky
      do_reset();
      seq(32'h8000_0000);
      seq(32'h8000_0008);
      check("brk pc_err", pc_err, 1);
      check("brk err_pc", err_pc, 32'h8000_0008);
      seq(32'h8000_0100);
      step();
      check("brk err_pc sticky", err_pc, 32'h8000_0008);

      // Overflow
      do_reset();
      bus.rd_ready = 0;
      for (int i = 0; i < 18; i++) seq(RPC + 32'(4 * i));
      step();
      check("ovf retire_cnt", retire_cnt, 18);
      check("ovf drop_cnt", drop_cnt, 2);
      check("ovf rd_valid", bus.rd_valid, 1);
      bus.rd_ready = 1;
      for (int i = 0; i < 20; i++) step();
      check("ovf record count", got.size(), 16);
      for (int i = 0; i < 16 && i < got.size(); i++) check("ovf record pc", got[i].pc, RPC + 32'(4 * i));
      check("ovf drained", bus.rd_valid, 0);

      // Halt and drain
      do_reset();
      bus.rd_ready = 0;
      seq(32'h8000_0000);
      seq(32'h8000_0004);
      do_commit(32'h8000_0008, 32'h8000_000c, 32'h8000_000c, HALT);
      seq(32'h8000_000c);
      seq(32'h8000_0010);
      check("halt drop_cnt", drop_cnt, 2);
      check("halt done early", done, 0);
      bus.rd_ready = 1;
      empty_cyc = -1;
      done_cyc  = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (empty_cyc < 0 && !bus.rd_valid) empty_cyc = i;
         if (done) begin
            done_cyc = i;
            break;
         end
      end
      check("halt done reached", done_cyc >= 0, 1);
      check("halt done latency", done_cyc - empty_cyc, 1);
      check("halt retire_cnt", retire_cnt, 5);
      check("halt record count", got.size(), 3);
      if (got.size() == 3) check("halt last record instr", got[2].instr, HALT);
      seq(32'h8000_0014);
      step();
      check("done ignores retire", retire_cnt, 5);
      check("done ignores drop", drop_cnt, 2);
      check("done stays", done, 1);

      // Reset mid-run with a coincident commit
      do_reset();
      bus.rd_ready = 0;
      for (int i = 0; i < 4; i++) seq(RPC + 32'(4 * i));
      check("mid rd_valid before", bus.rd_valid, 1);
      rst = 1'b1;
      bus.commit = 1; bus.commit_pc = 32'h8000_0010;
      bus.commit_pre_pc = 32'h8000_0014; bus.commit_pred_pc = 32'h8000_0018; bus.instr = NOP;
      step();
      rst = 1'b0;
      bus.commit = 0;
      check("mid rd_valid", bus.rd_valid, 0);
      check("mid retire_cnt", retire_cnt, 0);
      check("mid mispred_cnt", mispred_cnt, 0);
      check("mid drop_cnt", drop_cnt, 0);
      check("mid done", done, 0);
      seq(RPC);
      check("mid after pc_err", pc_err, 0);
      check("mid after retire_cnt", retire_cnt, 1);
      check("mid after rd_valid", bus.rd_valid, 1);
      check("mid after rd_pc", bus.rd_pc, RPC);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
